decoder_2_to_4: RTL and testbench
=================================

Name: decoder_2_to_4

Overview:
- Registered 2-to-4 line decoder with enable.
- The 2-bit select {W1,W0} drives exactly one bit of the 4-bit one-hot output q while En is high. q is all-zero while En is low.
- Used as a small address/select decoder feeding chip-select or mux-select logic. The output is registered, so downstream logic sees a glitch-free one-hot value.

Parameters:
- OUT_ACTIVE_LOW, default 0: when 1, every bit of q is inverted at the register input. Idle/reset value becomes 4'b1111 and the selected line becomes 0. All behaviour below is stated for the default 0; with 1, apply bitwise inversion to every q value.

Ports:
- clk  input  1  rising-edge clock; the single clock of the block.
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
- W0  input  1  select bit 0 (LSB).
- W1  input  1  select bit 1 (MSB).
- En  input  1  decode enable, active high.
- q  output  4  registered one-hot decode output.

Behaviour:
- The select index is sel = {W1,W0}: W1 is the MSB, W0 is the LSB.
- Next-state function, evaluated from the inputs sampled at a rising clk edge:
  - rst_n=0: q <= 4'b0000.
  - else if En=1: q <= 4'b0001 << sel.
  - else (En=0): q <= 4'b0000.
- Decode table with En=1:
  - sel 0 (W1=0,W0=0) -> q=4'b0001
  - sel 1 (W1=0,W0=1) -> q=4'b0010
  - sel 2 (W1=1,W0=0) -> q=4'b0100
  - sel 3 (W1=1,W0=1) -> q=4'b1000
- Latency: exactly one clock. q reflects the inputs sampled at the previous rising edge. There is no combinational path from the inputs to q.
- Reset:
  - rst_n is synchronous and takes priority over En and the select bits.
  - q reads 4'b0000 from the first edge sampled with rst_n=0 until the first edge sampled with rst_n=1 and En=1.
  - Asserting reset mid-operation clears q on the next edge regardless of the inputs.
  - There is no asynchronous clear. Before the first reset edge, q is undefined.
- Invariant: with En=1 and rst_n=1 at the previous edge, q has exactly one bit set. Otherwise q=0.
- Input changes between edges have no effect. Only values present at the rising edge matter.
- There is no internal state other than the 4-bit q register.
- X/Z on the select bits while En=1 is outside the supported input range. No behaviour is defined for it.

Test Plan:
- Reset: rst_n=0 for 2 cycles with En=1, W1=1, W0=1 -> q=4'b0000 on every edge. Release rst_n=1 -> q=4'b1000 one edge later.
- Full decode sweep with En=1: apply {W1,W0}=00,01,10,11 on successive cycles -> q=0001,0010,0100,1000, each one cycle after its select is applied. No cycle shows more than one bit set.
- Enable gating: En=0 with each of the 4 select values -> q=4'b0000 every cycle. Raise En=1 with sel=2 -> q=4'b0100 on the next edge. Drop En=0 -> q=4'b0000 on the following edge.
- Latency / no combinational path: change W0 mid-cycle (between edges) -> q does not change until the next rising edge. Toggle W0 several times within one cycle -> only the value at the edge is decoded.
- Reset mid-operation: running with En=1, sel=1 (q=4'b0010), assert rst_n=0 for one edge -> q=4'b0000. Deassert -> q=4'b0010 on the next edge.
- Parameter variant OUT_ACTIVE_LOW=1: reset -> q=4'b1111. En=1, sel=3 -> q=4'b0111. En=0 -> q=4'b1111.

Source files
------------

// File: rtl/decoder_2_to_4.sv
// ---------------------------------------------------------------------------
// decoder_2_to_4
//
// Registered 2-to-4 line decoder with enable. The 2-bit select {W1,W0}
// picks exactly one bit of the one-hot output q while En is high. q is
// all-zero while En is low. The output comes straight from a flop, so
// downstream chip-select or mux-select logic sees a glitch-free value one
// clock after the inputs are sampled.
//
// Parameters:
//   OUT_ACTIVE_LOW - 0: selected line is 1, idle/reset value is 4'b0000
//                    1: every bit is inverted before the register, so the
//                       selected line is 0 and idle/reset is 4'b1111
//
// Ports:
//   clk    in   1  rising-edge clock
//   rst_n  in   1  synchronous active-low reset, has priority over En/select
//   W0     in   1  select bit 0 (LSB)
//   W1     in   1  select bit 1 (MSB)
//   En     in   1  decode enable, active high
//   q      out  4  registered one-hot decode output
// ---------------------------------------------------------------------------
module decoder_2_to_4 #(
    parameter bit OUT_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       W0,
    input  logic       W1,
    input  logic       En,
    output logic [3:0] q
);

    // Idle pattern also serves as the reset value, so reset and En=0 look
    // identical downstream in either polarity.
    localparam logic [3:0] IDLE_VALUE = OUT_ACTIVE_LOW ? 4'b1111 : 4'b0000;

    logic [1:0] sel;
    logic [3:0] oneHot;
    logic [3:0] q_d;
    logic [3:0] q_q;

    assign sel = {W1, W0};

    // One-hot decode of the select index, gated by En. The polarity
    // inversion is applied here, ahead of the flop, so q never carries an
    // inverter on its output path.
    always_comb begin
        oneHot = 4'b0000;
        case (sel)
            2'd0:    oneHot = 4'b0001;
            2'd1:    oneHot = 4'b0010;
            2'd2:    oneHot = 4'b0100;
            default: oneHot = 4'b1000;
        endcase

        q_d = En ? oneHot : 4'b0000;
        if (OUT_ACTIVE_LOW) begin
            q_d = ~q_d;
        end
    end

    // The only state in the block: the output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= IDLE_VALUE;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: tb/tb_decoder_2_to_4.sv
// ---------------------------------------------------------------------------
// tb_decoder_2_to_4
//
// Self-checking bench for decoder_2_to_4. Two instances share the same
// stimulus: one with the default active-high output and one with
// OUT_ACTIVE_LOW=1, whose expected value is the bitwise inverse.
// ---------------------------------------------------------------------------
module tb_decoder_2_to_4;

    logic       clk;
    logic       rst_n;
    logic       W0;
    logic       W1;
    logic       En;
    logic [3:0] qHigh;
    logic [3:0] qLow;

    int checkCount;
    int failCount;

    typedef struct {
        string      name;
        logic       rstN;
        logic       en;
        logic       w1;
        logic       w0;
        logic [3:0] expQ;
    } vector_t;

    vector_t vectors[$];

    decoder_2_to_4 #(.OUT_ACTIVE_LOW(1'b0)) dutHigh (
        .clk   (clk),
        .rst_n (rst_n),
        .W0    (W0),
        .W1    (W1),
        .En    (En),
        .q     (qHigh)
    );

    decoder_2_to_4 #(.OUT_ACTIVE_LOW(1'b1)) dutLow (
        .clk   (clk),
        .rst_n (rst_n),
        .W0    (W0),
        .W1    (W1),
        .En    (En),
        .q     (qLow)
    );

    // 10 time-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives all inputs at once; called 1 time unit after a rising edge so
    // the values are stable well before the next edge.
    task automatic applyStimulus(input logic rstN, input logic en,
                                 input logic w1, input logic w0);
        rst_n = rstN;
        En    = en;
        W1    = w1;
        W0    = w0;
    endtask

    // Compares one output against its expected value; 4-state compare so an
    // X/Z output counts as a failure.
    task automatic checkOutput(input string name, input logic [3:0] actual,
                               input logic [3:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    // Checks both instances against one active-high expectation.
    task automatic checkBoth(input string name, input logic [3:0] expHigh);
        checkOutput({name, " (active-high)"}, qHigh, expHigh);
        checkOutput({name, " (active-low)"}, qLow, ~expHigh);
    endtask

    task automatic waitEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;

        // Each row: inputs held across one rising edge, then q checked.
        // Reset with select=3/En=1 must still read zero.
        vectors.push_back('{"reset 1",          1'b0, 1'b1, 1'b1, 1'b1, 4'b0000});
        vectors.push_back('{"reset 2",          1'b0, 1'b1, 1'b1, 1'b1, 4'b0000});
        vectors.push_back('{"reset release",    1'b1, 1'b1, 1'b1, 1'b1, 4'b1000});
        // Full decode sweep.
        vectors.push_back('{"sweep sel0",       1'b1, 1'b1, 1'b0, 1'b0, 4'b0001});
        vectors.push_back('{"sweep sel1",       1'b1, 1'b1, 1'b0, 1'b1, 4'b0010});
        vectors.push_back('{"sweep sel2",       1'b1, 1'b1, 1'b1, 1'b0, 4'b0100});
        vectors.push_back('{"sweep sel3",       1'b1, 1'b1, 1'b1, 1'b1, 4'b1000});
        // Enable gating.
        vectors.push_back('{"en0 sel0",         1'b1, 1'b0, 1'b0, 1'b0, 4'b0000});
        vectors.push_back('{"en0 sel1",         1'b1, 1'b0, 1'b0, 1'b1, 4'b0000});
        vectors.push_back('{"en0 sel2",         1'b1, 1'b0, 1'b1, 1'b0, 4'b0000});
        vectors.push_back('{"en0 sel3",         1'b1, 1'b0, 1'b1, 1'b1, 4'b0000});
        vectors.push_back('{"en1 sel2",         1'b1, 1'b1, 1'b1, 1'b0, 4'b0100});
        vectors.push_back('{"en drop",          1'b1, 1'b0, 1'b1, 1'b0, 4'b0000});
        // Reset mid-operation.
        vectors.push_back('{"run sel1",         1'b1, 1'b1, 1'b0, 1'b1, 4'b0010});
        vectors.push_back('{"mid reset",        1'b0, 1'b1, 1'b0, 1'b1, 4'b0000});
        vectors.push_back('{"mid reset release",1'b1, 1'b1, 1'b0, 1'b1, 4'b0010});

        $display("[TB] starting, %0d table vectors", vectors.size());

        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        #1;
        foreach (vectors[i]) begin
            applyStimulus(vectors[i].rstN, vectors[i].en, vectors[i].w1, vectors[i].w0);
            waitEdge();
            checkBoth(vectors[i].name, vectors[i].expQ);
        end

        // Latency / no combinational path: q currently holds 0010 from the
        // last table row. Change the select several times between edges;
        // q must not move until the edge, which decodes only the final value.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        checkBoth("mid-cycle W0 change", 4'b0010);
        for (int t = 0; t < 4; t++) begin
            W0 = ~W0;
            #1;
            checkBoth("mid-cycle W0 toggle", 4'b0010);
        end
        // Final pre-edge value: W1=1, W0=0 -> sel 2.
        W1 = 1'b1;
        W0 = 1'b0;
        waitEdge();
        checkBoth("edge decodes last value", 4'b0100);

        // Inputs changing just after the edge must not disturb q.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        #2;
        checkBoth("hold after edge", 4'b0100);
        waitEdge();
        checkBoth("en0 after hold", 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
